mult_div_unit: RTL and testbench

- Multicycle signed multiply/divide unit for the MIPS datapath; executes MULT and DIV and owns the HI and LO registers.
- hi_out and lo_out feed the write-back register-select mux as the HI and LO sources for MFHI and MFLO.
- The control FSM pulses a start strobe and waits on busy/done before issuing MFHI/MFLO; div_zero drives the divide-by-zero exception path.

---
 rtl/mult_div_unit.sv | 142 ++++++++++++++
 tb/tb_mult_div_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply/divide unit owning the HI/LO registers.
// MULT uses radix-2 Booth; DIV uses restoring division on operand magnitudes.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mult_start,
  input  logic             div_start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, MULT, DIV, FIN} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    count;
  logic             last;

  logic [2*WIDTH:0] acc, acc_nxt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH:0]   booth_sum;

  logic [WIDTH-1:0] rem, rem_nxt, quo, quo_nxt, dvs;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             sign_q, sign_r, dz;

  assign last     = (count == CW'(WIDTH - 1));
  assign busy     = (state == MULT) || (state == DIV);
  assign done     = (state == FIN);
  assign div_zero = (state == FIN) && dz;

  assign a_mag = a_in[WIDTH-1] ? -a_in : a_in;
  assign b_mag = b_in[WIDTH-1] ? -b_in : b_in;

  // Upper half is widened by one bit so a -2^(W-1) multiplicand cannot overflow the add.
  always_comb begin
    booth_sum = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]};
    case (acc[1:0])
      2'b01:   booth_sum = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]} + {mcand[WIDTH-1], mcand};
      2'b10:   booth_sum = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]} - {mcand[WIDTH-1], mcand};
      default: booth_sum = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]};
    endcase
    acc_nxt = {booth_sum, acc[WIDTH:1]};
  end

  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    if (shifted >= {1'b0, dvs}) begin
      rem_nxt = shifted[WIDTH-1:0] - dvs;
      quo_nxt = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_nxt = shifted[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (mult_start)                state_nxt = MULT;
        else if (div_start && b_in == '0) state_nxt = FIN;
        else if (div_start)            state_nxt = DIV;
      end
      MULT:    if (last) state_nxt = FIN;
      DIV:     if (last) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_out <= '0;
      lo_out <= '0;
      count  <= '0;
      acc    <= '0;
      mcand  <= '0;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      dz     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mult_start) begin
            mcand <= a_in;
            acc   <= {{WIDTH{1'b0}}, b_in, 1'b0};
            count <= '0;
            dz    <= 1'b0;
          end else if (div_start) begin
            dz <= (b_in == '0);
            if (b_in != '0) begin
              rem    <= '0;
              quo    <= a_mag;
              dvs    <= b_mag;
              sign_q <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
              sign_r <= a_in[WIDTH-1];
              count  <= '0;
            end
          end
        end
        MULT: begin
          acc   <= acc_nxt;
          count <= count + CW'(1);
          if (last) begin
            hi_out <= acc_nxt[2*WIDTH:WIDTH+1];
            lo_out <= acc_nxt[WIDTH:1];
          end
        end
        DIV: begin
          rem   <= rem_nxt;
          quo   <= quo_nxt;
          count <= count + CW'(1);
          // Quotient truncates toward zero; remainder follows the dividend's sign.
          if (last) begin
            lo_out <= sign_q ? -quo_nxt : quo_nxt;
            hi_out <= sign_r ? -rem_nxt : rem_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus randomized ops
// against a plain-arithmetic reference model of HI/LO.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset, mult_start, div_start;
  logic [31:0] a_in, b_in, hi_out, lo_out;
  logic        busy, done, div_zero;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_hi = '0, exp_lo = '0;
  bit          exp_dz;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .mult_start(mult_start), .div_start(div_start),
    .a_in(a_in), .b_in(b_in), .hi_out(hi_out), .lo_out(lo_out),
    .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  // Reference: 64-bit signed arithmetic; SV / and % truncate toward zero.
  task automatic model(input bit is_mult, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p, q, r;
    sa = $signed(a);
    sb = $signed(b);
    exp_dz = 1'b0;
    if (is_mult) begin
      p = sa * sb;
      exp_hi = p[63:32];
      exp_lo = p[31:0];
    end else if (b == 32'd0) begin
      exp_dz = 1'b1;
    end else begin
      q = sa / sb;
      r = sa % sb;
      exp_lo = q[31:0];
      exp_hi = r[31:0];
    end
  endtask

  // Drives one request, then observes cycle by cycle until done (bounded).
  task automatic run_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                        input int pulse_cyc, output int done_cyc, output int busy_cnt,
                        output int dz_cnt, output int chg_cnt);
    logic [31:0] h0, l0;
    done_cyc = -1; busy_cnt = 0; dz_cnt = 0; chg_cnt = 0;
    @(negedge clk);
    h0 = hi_out; l0 = lo_out;
    mult_start = m; div_start = d; a_in = a; b_in = b;
    @(posedge clk);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (div_zero) dz_cnt++;
      if (busy && (hi_out !== h0 || lo_out !== l0)) chg_cnt++;
      if (done && done_cyc < 0) done_cyc = c;
      mult_start = (c == pulse_cyc);
      div_start  = (c == pulse_cyc);
      a_in = $urandom;
      b_in = $urandom;
      if (done) break;
    end
    @(negedge clk);
    mult_start = 1'b0; div_start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; mult_start = 1'b0; div_start = 1'b0; a_in = '0; b_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks += 5;
    if (hi_out !== 32'd0) begin errors++; $display("FAIL reset_hi got %h want 0", hi_out); end
    if (lo_out !== 32'd0) begin errors++; $display("FAIL reset_lo got %h want 0", lo_out); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    if (div_zero !== 1'b0) begin errors++; $display("FAIL reset_dz got %b want 0", div_zero); end
    reset = 1'b0;
    exp_hi = '0; exp_lo = '0;
  endtask

  task automatic test_mult_directed;
    int dc, bc, zc, cc;
    run_op(1, 0, 32'h00000007, 32'hFFFFFFFD, 0, dc, bc, zc, cc);
    model(1, 32'h00000007, 32'hFFFFFFFD);
    checks += 6;
    if (dc != 33) begin errors++; $display("FAIL mul7_done_cyc got %0d want 33", dc); end
    if (bc != 32) begin errors++; $display("FAIL mul7_busy_cycles got %0d want 32", bc); end
    if (cc != 0) begin errors++; $display("FAIL mul7_stable got %0d changes want 0", cc); end
    if (zc != 0) begin errors++; $display("FAIL mul7_dz got %0d want 0", zc); end
    if (hi_out !== 32'hFFFFFFFF) begin errors++; $display("FAIL mul7_hi got %h want ffffffff", hi_out); end
    if (lo_out !== 32'hFFFFFFEB) begin errors++; $display("FAIL mul7_lo got %h want ffffffeb", lo_out); end
    run_op(1, 0, 32'h80000000, 32'h80000000, 0, dc, bc, zc, cc);
    model(1, 32'h80000000, 32'h80000000);
    checks += 2;
    if (hi_out !== 32'h40000000) begin errors++; $display("FAIL mulmin_hi got %h want 40000000", hi_out); end
    if (lo_out !== 32'h00000000) begin errors++; $display("FAIL mulmin_lo got %h want 0", lo_out); end
  endtask

  task automatic test_div_directed;
    logic [31:0] tbl [3][4] = '{
      '{32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD},
      '{32'h00000064, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2},
      '{32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000}};
    int dc, bc, zc, cc;
    for (int i = 0; i < 3; i++) begin
      run_op(0, 1, tbl[i][0], tbl[i][1], 0, dc, bc, zc, cc);
      model(0, tbl[i][0], tbl[i][1]);
      checks += 4;
      if (dc != 33) begin errors++; $display("FAIL div%0d_done_cyc got %0d want 33", i, dc); end
      if (zc != 0) begin errors++; $display("FAIL div%0d_dz got %0d want 0", i, zc); end
      if (hi_out !== tbl[i][2]) begin errors++; $display("FAIL div%0d_hi got %h want %h", i, hi_out, tbl[i][2]); end
      if (lo_out !== tbl[i][3]) begin errors++; $display("FAIL div%0d_lo got %h want %h", i, lo_out, tbl[i][3]); end
    end
  endtask

  task automatic test_div_zero;
    int dc, bc, zc, cc;
    logic [31:0] h, l;
    h = exp_hi; l = exp_lo;
    run_op(0, 1, 32'd5, 32'd0, 0, dc, bc, zc, cc);
    checks += 5;
    if (dc != 1) begin errors++; $display("FAIL dz_done_cyc got %0d want 1", dc); end
    if (zc != 1) begin errors++; $display("FAIL dz_pulses got %0d want 1", zc); end
    if (bc != 0) begin errors++; $display("FAIL dz_busy got %0d want 0", bc); end
    if (hi_out !== h) begin errors++; $display("FAIL dz_hi_hold got %h want %h", hi_out, h); end
    if (lo_out !== l) begin errors++; $display("FAIL dz_lo_hold got %h want %h", lo_out, l); end
  endtask

  task automatic test_both_starts;
    int dc, bc, zc, cc;
    run_op(1, 1, 32'd6, 32'd3, 0, dc, bc, zc, cc);
    model(1, 32'd6, 32'd3);
    checks += 4;
    if (dc != 33) begin errors++; $display("FAIL both_done_cyc got %0d want 33", dc); end
    if (zc != 0) begin errors++; $display("FAIL both_dz got %0d want 0", zc); end
    if (lo_out !== 32'd18) begin errors++; $display("FAIL both_lo got %h want 12", lo_out); end
    if (hi_out !== 32'd0) begin errors++; $display("FAIL both_hi got %h want 0", hi_out); end
  endtask

  task automatic test_ignored_starts;
    int dc, bc, zc, cc;
    logic [31:0] a, b;
    a = $urandom; b = $urandom;
    run_op(1, 0, a, b, 10, dc, bc, zc, cc);
    model(1, a, b);
    checks += 4;
    if (dc != 33) begin errors++; $display("FAIL busy_start_done_cyc got %0d want 33", dc); end
    if (cc != 0) begin errors++; $display("FAIL busy_start_stable got %0d changes want 0", cc); end
    if (hi_out !== exp_hi) begin errors++; $display("FAIL busy_start_hi got %h want %h", hi_out, exp_hi); end
    if (lo_out !== exp_lo) begin errors++; $display("FAIL busy_start_lo got %h want %h", lo_out, exp_lo); end
    a = $urandom; b = $urandom_range(1, 1000);
    run_op(0, 1, a, b, 33, dc, bc, zc, cc);
    model(0, a, b);
    checks += 4;
    if (busy !== 1'b0) begin errors++; $display("FAIL fin_start_busy got %b want 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL fin_start_done got %b want 0", done); end
    if (hi_out !== exp_hi) begin errors++; $display("FAIL fin_start_hi got %h want %h", hi_out, exp_hi); end
    if (lo_out !== exp_lo) begin errors++; $display("FAIL fin_start_lo got %h want %h", lo_out, exp_lo); end
  endtask

  task automatic test_reset_mid;
    int dc, bc, zc, cc;
    @(negedge clk);
    mult_start = 1'b1; a_in = $urandom; b_in = $urandom;
    @(posedge clk);
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      if (c == 15) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b want 1", busy); end
      end
      if (c == 21) begin
        checks += 5;
        if (hi_out !== 32'd0) begin errors++; $display("FAIL mid_reset_hi got %h want 0", hi_out); end
        if (lo_out !== 32'd0) begin errors++; $display("FAIL mid_reset_lo got %h want 0", lo_out); end
        if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy got %b want 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL mid_reset_done got %b want 0", done); end
        if (div_zero !== 1'b0) begin errors++; $display("FAIL mid_reset_dz got %b want 0", div_zero); end
      end
      mult_start = (c == 10);
      div_start  = (c == 10);
      reset      = (c == 20);
    end
    exp_hi = '0; exp_lo = '0;
    run_op(1, 0, 32'd3, 32'd4, 0, dc, bc, zc, cc);
    model(1, 32'd3, 32'd4);
    checks += 3;
    if (dc != 33) begin errors++; $display("FAIL post_reset_done_cyc got %0d want 33", dc); end
    if (lo_out !== 32'd12) begin errors++; $display("FAIL post_reset_lo got %h want c", lo_out); end
    if (hi_out !== 32'd0) begin errors++; $display("FAIL post_reset_hi got %h want 0", hi_out); end
  endtask

  task automatic test_random;
    int dc, bc, zc, cc, kind;
    logic [31:0] a, b;
    logic [31:0] corner [5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
    for (int i = 0; i < 24; i++) begin
      kind = $urandom_range(0, 1);
      a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      if (kind == 1 && $urandom_range(0, 5) == 0) b = 32'd0;
      if ($urandom_range(0, 2) == 0) b = $urandom_range(1, 20);
      run_op(kind == 0, kind == 1, a, b, 0, dc, bc, zc, cc);
      model(kind == 0, a, b);
      checks += 4;
      if (dc != (exp_dz ? 1 : 33)) begin errors++; $display("FAIL rnd%0d_done_cyc got %0d want %0d", i, dc, exp_dz ? 1 : 33); end
      if (zc != int'(exp_dz)) begin errors++; $display("FAIL rnd%0d_dz got %0d want %0d", i, zc, exp_dz); end
      if (hi_out !== exp_hi) begin errors++; $display("FAIL rnd%0d_hi a=%h b=%h got %h want %h", i, a, b, hi_out, exp_hi); end
      if (lo_out !== exp_lo) begin errors++; $display("FAIL rnd%0d_lo a=%h b=%h got %h want %h", i, a, b, lo_out, exp_lo); end
    end
  endtask

  initial begin
    test_reset;
    test_mult_directed;
    test_div_directed;
    test_div_zero;
    test_both_starts;
    test_ignored_starts;
    test_reset_mid;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
